tlv5618a_receiver: RTL and testbench

//  Synthesizable responder for the TLV5618A 3-wire DAC link (sclk/din/csn).

---
 rtl/tlv5618a_pkg.sv | 26 ++
 rtl/tlv5618a_if.sv | 9 +
 rtl/tlv5618a_sync_edge.sv | 30 +++
 rtl/tlv5618a_receiver.sv | 131 +++++++++++++
 tb/tb_tlv5618a_receiver.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/tlv5618a_pkg.sv
// rtl/tlv5618a_pkg.sv - shared constants, word-select codes and FSM states for the TLV5618A receiver
package tlv5618a_pkg;

  localparam int WORD_BITS = 16;
  localparam int DATA_BITS = 12;

  // R1R0 control field, taken from D15 and D12 of the word.
  typedef enum logic [1:0] {
    SEL_B_BUF = 2'b00,
    SEL_BUF   = 2'b01,
    SEL_A_UPD = 2'b10,
    SEL_RSVD  = 2'b11
  } sel_e;

  typedef enum logic [1:0] {
    ST_WAIT_HIGH = 2'd0,
    ST_IDLE      = 2'd1,
    ST_SHIFT     = 2'd2,
    ST_COMMIT    = 2'd3
  } state_e;

  function automatic sel_e word_sel(input logic [WORD_BITS-1:0] word);
    return sel_e'({word[WORD_BITS-1], word[WORD_BITS-4]});
  endfunction

endpackage

// File: rtl/tlv5618a_if.sv
// rtl/tlv5618a_if.sv - 3-wire TLV5618A DAC link (sclk/din/csn)
interface tlv5618a_if;
  logic dac_sclk;
  logic dac_din;
  logic dac_csn;

  modport master (output dac_sclk, output dac_din, output dac_csn);
  modport slave  (input  dac_sclk, input  dac_din, input  dac_csn);
endinterface

// File: rtl/tlv5618a_sync_edge.sv
// rtl/tlv5618a_sync_edge.sv - multi-stage synchronizer with rise/fall pulses on the synchronized level
module sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic sync_out,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain_q;
  logic              prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      chain_q <= '0;
      prev_q  <= 1'b0;
    end else begin
      chain_q <= {chain_q[STAGES-2:0], async_in};
      prev_q  <= chain_q[STAGES-1];
    end
  end

  assign sync_out = chain_q[STAGES-1];
  assign rise     = sync_out & ~prev_q;
  assign fall     = ~sync_out & prev_q;

endmodule

// File: rtl/tlv5618a_receiver.sv
// rtl/tlv5618a_receiver.sv - oversampling TLV5618A link responder decoding words into DAC A/B/BUFFER
module tlv5618a_receiver #(
  parameter int SYNC_STAGES = 2,
  parameter int WORD_BITS   = 16
) (
  input  logic              clk,
  input  logic              rst,
  tlv5618a_if.slave         link,
  output logic [11:0]       dac_a,
  output logic [11:0]       dac_b,
  output logic [11:0]       buffer,
  output logic              pwr_down,
  output logic              speed,
  output logic              update,
  output logic              frame_err
);
  import tlv5618a_pkg::*;

  localparam int              CNT_W    = $clog2(WORD_BITS + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WORD_BITS);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(WORD_BITS + 1);

  logic sclk_sync, sclk_rise, sclk_fall;
  logic csn_sync, csn_rise, csn_fall;
  logic [SYNC_STAGES-1:0] din_q;
  logic din_sync;
  logic link_unused;

  sync_edge #(.STAGES(SYNC_STAGES)) u_sclk (
    .clk(clk), .rst(rst), .async_in(link.dac_sclk),
    .sync_out(sclk_sync), .rise(sclk_rise), .fall(sclk_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES)) u_csn (
    .clk(clk), .rst(rst), .async_in(link.dac_csn),
    .sync_out(csn_sync), .rise(csn_rise), .fall(csn_fall)
  );

  // Same depth as the sclk path so din is sampled alongside the edge that clocks it.
  always_ff @(posedge clk) begin
    if (rst) din_q <= '0;
    else     din_q <= {din_q[SYNC_STAGES-2:0], link.dac_din};
  end
  assign din_sync    = din_q[SYNC_STAGES-1];
  assign link_unused = sclk_sync ^ sclk_rise;

  state_e                 state_q, state_d;
  logic                   clr_frame, shift_en, do_commit;
  logic [CNT_W-1:0]       cnt_q;
  logic [WORD_BITS-1:0]   sr_q;
  logic [DATA_BITS-1:0]   word_data;

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_WAIT_HIGH;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    clr_frame = 1'b0;
    shift_en  = 1'b0;
    do_commit = 1'b0;
    case (state_q)
      ST_WAIT_HIGH: if (csn_sync) state_d = ST_IDLE;
      ST_IDLE: begin
        if (csn_fall) begin
          state_d   = ST_SHIFT;
          clr_frame = 1'b1;
        end
      end
      ST_SHIFT: begin
        // A final sclk fall in the same sample as csn rise still counts.
        shift_en = sclk_fall;
        if (csn_rise) state_d = ST_COMMIT;
      end
      ST_COMMIT: begin
        do_commit = 1'b1;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_WAIT_HIGH;
    endcase
  end

  assign word_data = sr_q[DATA_BITS-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      sr_q      <= '0;
      dac_a     <= '0;
      dac_b     <= '0;
      buffer    <= '0;
      pwr_down  <= 1'b0;
      speed     <= 1'b0;
      update    <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      update    <= 1'b0;
      frame_err <= 1'b0;
      if (clr_frame) begin
        cnt_q <= '0;
        sr_q  <= '0;
      end else if (shift_en) begin
        sr_q <= {sr_q[WORD_BITS-2:0], din_sync};
        if (cnt_q != CNT_SAT) cnt_q <= cnt_q + 1'b1;
      end
      if (do_commit) begin
        if (cnt_q != CNT_FULL) begin
          frame_err <= 1'b1;
        end else if (word_sel(sr_q) != SEL_RSVD) begin
          speed    <= sr_q[WORD_BITS-2];
          pwr_down <= sr_q[WORD_BITS-3];
          update   <= 1'b1;
          case (word_sel(sr_q))
            SEL_B_BUF: begin
              dac_b  <= word_data;
              buffer <= word_data;
            end
            SEL_BUF:   buffer <= word_data;
            SEL_A_UPD: begin
              dac_a <= word_data;
              dac_b <= buffer;
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_tlv5618a_receiver.sv
// tb/tb_tlv5618a_receiver.sv - randomized self-checking bench for tlv5618a_receiver
module tb_tlv5618a_receiver;

  localparam int SYNC = 2;
  localparam int HALF = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  tlv5618a_if link();

  logic [11:0] dac_a, dac_b, buffer;
  logic        pwr_down, speed, update, frame_err;

  tlv5618a_receiver #(.SYNC_STAGES(SYNC), .WORD_BITS(16)) dut (
    .clk(clk), .rst(rst), .link(link.slave),
    .dac_a(dac_a), .dac_b(dac_b), .buffer(buffer),
    .pwr_down(pwr_down), .speed(speed),
    .update(update), .frame_err(frame_err)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int upd_cnt  = 0;
  int err_cnt  = 0;
  int last_upd_cyc = -1;
  int last_err_cyc = -1;
  int rise_cyc = 0;

  logic [11:0] m_a, m_b, m_buf;
  logic        m_pd, m_spd;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (update === 1'b1) begin
      upd_cnt      <= upd_cnt + 1;
      last_upd_cyc <= cyc;
    end
    if (frame_err === 1'b1) begin
      err_cnt      <= err_cnt + 1;
      last_err_cyc <= cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_a = '0; m_b = '0; m_buf = '0; m_pd = 1'b0; m_spd = 1'b0;
  endtask

  // Word-level TLV5618A rules: what a closed frame of n bits does to the registers.
  task automatic model_frame(input logic [31:0] w, input int n, output bit e_upd, output bit e_err);
    logic [11:0] d;
    e_upd = 0;
    e_err = (n != 16);
    if (!e_err) begin
      d = w[11:0];
      case ({w[15], w[12]})
        2'b00: begin m_b = d; m_buf = d; end
        2'b01: m_buf = d;
        2'b10: begin m_a = d; m_b = m_buf; end
        default: ;
      endcase
      if ({w[15], w[12]} != 2'b11) begin
        m_spd = w[14];
        m_pd  = w[13];
        e_upd = 1;
      end
    end
  endtask

  task automatic clock_bits(input logic [31:0] w, input int n, input bit close_on_last);
    for (int i = n - 1; i >= 0; i--) begin
      link.dac_din  = w[i];
      link.dac_sclk = 1'b1;
      wait_clk(HALF);
      link.dac_sclk = 1'b0;
      if (i == 0 && close_on_last) begin
        link.dac_csn = 1'b1;
        rise_cyc     = cyc;
      end
      wait_clk(HALF);
    end
  endtask

  task automatic send_frame(input logic [31:0] w, input int n, input bit sim);
    link.dac_csn = 1'b0;
    wait_clk(HALF);
    clock_bits(w, n, sim);
    if (!sim) begin
      link.dac_csn = 1'b1;
      rise_cyc     = cyc;
    end
    link.dac_din = 1'b0;
  endtask

  task automatic check_regs(input string tag);
    check({tag, " dac_a"}, 32'(dac_a), 32'(m_a));
    check({tag, " dac_b"}, 32'(dac_b), 32'(m_b));
    check({tag, " buffer"}, 32'(buffer), 32'(m_buf));
    check({tag, " pwr/spd"}, {30'd0, pwr_down, speed}, {30'd0, m_pd, m_spd});
  endtask

  task automatic run_frame(input logic [31:0] w, input int n, input bit sim, input string tag);
    int  u0, e0;
    bit  eu, ee;
    u0 = upd_cnt;
    e0 = err_cnt;
    model_frame(w, n, eu, ee);
    send_frame(w, n, sim);
    wait_clk(SYNC + 10);
    check({tag, " update pulses"}, upd_cnt - u0, 32'(eu));
    check({tag, " frame_err pulses"}, err_cnt - e0, 32'(ee));
    if (eu) check({tag, " update latency"}, last_upd_cyc - rise_cyc, SYNC + 2);
    if (ee) check({tag, " frame_err latency"}, last_err_cyc - rise_cyc, SYNC + 2);
    check_regs(tag);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int u0, e0, n;
    logic [31:0] w;
    bit sim;

    rst = 1'b1;
    link.dac_sclk = 1'b0;
    link.dac_din  = 1'b0;
    link.dac_csn  = 1'b1;
    model_reset();
    wait_clk(3);
    rst = 1'b0;
    wait_clk(20);
    check("reset update pulses", upd_cnt, 0);
    check("reset frame_err pulses", err_cnt, 0);
    check_regs("reset");

    run_frame(32'h1FFF, 16, 0, "buf load");
    run_frame(32'h80E4, 16, 0, "a update");
    run_frame(32'h2123, 16, 1, "b+buf pwr");
    run_frame(32'h02AB, 10, 0, "short frame");
    run_frame(32'h1ABCD, 17, 1, "long frame");
    run_frame(32'h9ABC, 16, 0, "reserved");

    // Reset mid-frame with csn held low: the rest of that frame must be ignored.
    u0 = upd_cnt;
    e0 = err_cnt;
    link.dac_csn = 1'b0;
    wait_clk(HALF);
    clock_bits(32'h0015, 5, 0);
    rst = 1'b1;
    wait_clk(2);
    rst = 1'b0;
    model_reset();
    check_regs("mid reset");
    clock_bits(32'h0456, 16, 0);
    link.dac_csn = 1'b1;
    wait_clk(SYNC + 10);
    check("orphan frame update", upd_cnt - u0, 0);
    check("orphan frame frame_err", err_cnt - e0, 0);
    check_regs("orphan frame");
    run_frame(32'h0456, 16, 0, "after reset");

    for (int k = 0; k < 30; k++) begin
      w   = $urandom;
      n   = ($urandom_range(0, 3) != 0) ? 16 : $urandom_range(1, 20);
      sim = $urandom_range(0, 1);
      run_frame(w, n, sim, $sformatf("rand%0d", k));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
